// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and helpers for the FIFO read-side stream adapter.
// Legal read latencies, buffer depth derivation and statistics counter width.
package fifo_rd_stream_pkg;

  localparam int RDLAT_MIN = 1;
  localparam int RDLAT_MAX = 2;
  localparam int STAT_W    = 16;

  // The buffer needs room for every in-flight read plus the word on display.
  function automatic int depth_f(input int rdlat);
    return rdlat + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// Small circular buffer used by fifo_rd_stream to absorb in-flight FIFO reads.
// Head entry is presented combinationally from registers; level counts entries.
module fifo_rd_stream_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 3,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [LVL_W-1:0] level_q, level_d;

  // Pointers wrap from the last entry back to zero (depth need not be 2^n).
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state: write at tail on push, advance head on pop, track occupancy.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    if (push) begin
      mem_d[tail_q] = push_data;
      tail_d        = next_ptr(tail_q);
    end
    if (pop) begin
      head_d = next_ptr(head_q);
    end
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // State registers; storage is cleared too so the idle head reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end

  assign head_data = mem_q[head_q];
  assign level     = level_q;

  // The issue logic in the parent reserves space, so a full buffer never takes a push.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (level_q == LVL_W'(DEPTH))));

  a_depth_range: assert property (@(posedge clk) DEPTH <= depth_f(RDLAT_MAX));

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read/empty/q to valid/ready stream adapter with a fixed read latency.
// Handshake: a word transfers on a rising clk edge where out_valid && out_ready;
// out_valid never drops and out_data never changes while a word waits.
// Optional FIFO_RD_STREAM_STATS_EN adds stall_cnt / starve_cnt saturating counters.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int RDLAT = 2,
  localparam int DEPTH = depth_f(RDLAT),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_read,
  input  logic [WIDTH-1:0]  fifo_q,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LVL_W-1:0]  level
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] starve_cnt
`endif
);

  localparam int INF_W = $clog2(RDLAT + 1);
  localparam int CNT_W = LVL_W + 1;

  logic [RDLAT-1:0] rd_vld_q, rd_vld_d;
  logic [INF_W-1:0] inflight;
  logic [CNT_W-1:0] occ;
  logic             push;
  logic             pop;

  // Count reads whose data has not yet landed in the buffer.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RDLAT; i++) inflight = inflight + INF_W'(rd_vld_q[i]);
  end

  assign pop  = out_valid && out_ready;
  assign push = rd_vld_q[RDLAT-1];

  // Issue only when the word can be guaranteed a buffer slot on arrival.
  assign occ       = CNT_W'(inflight) + CNT_W'(level) - CNT_W'(pop);
  assign fifo_read = !rst && !fifo_empty && (occ < CNT_W'(DEPTH));

  // Return pipeline: stage 0 marks this cycle's read, last stage marks q valid.
  always_comb begin
    rd_vld_d[0] = fifo_read;
    for (int i = 1; i < RDLAT; i++) rd_vld_d[i] = rd_vld_q[i-1];
  end

  // Reset drops all pending returns so late q from before reset is ignored.
  always_ff @(posedge clk) begin
    if (rst) rd_vld_q <= '0;
    else     rd_vld_q <= rd_vld_d;
  end

  fifo_rd_stream_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fifo_q),
    .pop       (pop),
    .head_data (out_data),
    .level     (level)
  );

  assign out_valid = (level != '0);

  a_rdlat_range: assert property (@(posedge clk)
    (RDLAT >= RDLAT_MIN) && (RDLAT <= RDLAT_MAX));

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STAT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Saturating counters for consumer backpressure and source starvation.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    starve_cnt_d = starve_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
    if (!out_valid && out_ready && fifo_empty && (inflight == '0) && (starve_cnt_q != '1)) begin
      starve_cnt_d = starve_cnt_q + STAT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign starve_cnt = starve_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: instance 0 uses RDLAT=1, instance 1 uses RDLAT=2.
// Each instance has its own behavioural FIFO (array + latency delay) feeding it.
module tb_fifo_rd_stream;
  import fifo_rd_stream_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   rst = 2'b11;
  logic [1:0]   fifo_empty;
  logic [1:0]   fifo_read;
  logic [1:0]   out_valid;
  logic [1:0]   out_ready = 2'b00;
  logic [W-1:0] fifo_q   [2];
  logic [W-1:0] out_data [2];
  logic [1:0]   level    [2];
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [STAT_W-1:0] stall_cnt  [2];
  logic [STAT_W-1:0] starve_cnt [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fifo_rd_stream #(.WIDTH(W), .RDLAT(g + 1)) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .fifo_empty (fifo_empty[g]),
      .fifo_read  (fifo_read[g]),
      .fifo_q     (fifo_q[g]),
      .out_data   (out_data[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .level      (level[g])
`ifdef FIFO_RD_STREAM_STATS_EN
      ,
      .stall_cnt  (stall_cnt[g]),
      .starve_cnt (starve_cnt[g])
`endif
    );
  end

  // ---------------- behavioural FIFO models ----------------
  logic [W-1:0] fmem [2][256];
  int           fwr [2] = '{0, 0};
  int           frd [2] = '{0, 0};
  logic         st_v = 1'b0;
  logic [W-1:0] st_d = '0;

  always_comb begin
    for (int i = 0; i < 2; i++) fifo_empty[i] = (fwr[i] == frd[i]);
  end

  // Read data appears RDLAT cycles after the read; otherwise q carries junk.
  always @(posedge clk) begin
    logic [W-1:0] nd;
    for (int i = 0; i < 2; i++) begin
      nd = fmem[i][frd[i] % 256];
      if (rst[i])            frd[i] <= fwr[i];
      else if (fifo_read[i]) frd[i] <= frd[i] + 1;
      if (i == 0) begin
        fifo_q[0] <= fifo_read[0] ? nd : W'($urandom);
      end else begin
        fifo_q[1] <= st_v ? st_d : W'($urandom);
        st_v      <= fifo_read[1];
        st_d      <= nd;
      end
    end
  end

  // ---------------- scoreboard / checking ----------------
  int           total = 0;
  int           bad   = 0;
  int           sel   = 0;
  logic [W-1:0] exp_q [$];
  int           nbeats, nreads;
  logic         have_prev, prev_valid, prev_ready;
  logic [W-1:0] prev_data;
  logic         o_valid, o_read;
  logic [W-1:0] o_data;
  logic [1:0]   o_level;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d t=%0t act=%0h exp=%0h", name, sel, $time, act, exp);
    end
  endtask

  task automatic set_sel(input int s);
    sel       = s;
    rst       = 2'b11;
    out_ready = 2'b00;
  endtask

  task automatic load(input logic [W-1:0] d);
    fmem[sel][fwr[sel] % 256] = d;
    fwr[sel]++;
    exp_q.push_back(d);
  endtask

  // One clock cycle: drive at negedge, observe 1ns later, apply stream rules.
  task automatic tick(input logic r, input logic rdy);
    @(negedge clk);
    rst[sel]       = r;
    out_ready[sel] = rdy;
    #1;
    o_valid = out_valid[sel];
    o_data  = out_data[sel];
    o_level = level[sel];
    o_read  = fifo_read[sel];
    if (r) begin
      chk("read_in_rst", o_read, 1'b0);
      exp_q.delete();
      have_prev = 1'b0;
    end else begin
      if (fifo_empty[sel]) chk("read_when_empty", o_read, 1'b0);
      chk("level_range", (o_level <= 2'(sel + 2)), 1'b1);
      if (have_prev && prev_valid && !prev_ready) begin
        chk("hold_valid", o_valid, 1'b1);
        chk("hold_data", o_data, prev_data);
      end
      if (o_valid && rdy) begin
        if (exp_q.size() == 0) chk("unexpected_beat", o_data, 32'hFFFF_FFFF);
        else begin
          chk("beat_data", o_data, exp_q.pop_front());
          nbeats++;
        end
      end
      if (o_read) nreads++;
      prev_valid = o_valid;
      prev_ready = rdy;
      prev_data  = o_data;
      have_prev  = 1'b1;
    end
  endtask

  // Two reset cycles, then stop just past the last reset edge.
  task automatic do_reset();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    @(posedge clk);
    #1;
    exp_q.delete();
    nbeats    = 0;
    nreads    = 0;
    have_prev = 1'b0;
  endtask

  typedef struct {
    logic         rdy;
    logic         rd;
    logic         vld;
    logic [1:0]   lvl;
    logic [W-1:0] dat;
  } vec_t;
  vec_t tbl [12];

  initial begin
    logic [W-1:0] wa, wb;
    // Backpressure with RDLAT=2, 10 words preloaded, ready low for 8 cycles.
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 2'd0, 16'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'd0, 16'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'd0, 16'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 2'd1, 16'd1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 2'd2, 16'd1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 2'd3, 16'd1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 2'd3, 16'd1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 2'd3, 16'd1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 2'd3, 16'd1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 2'd2, 16'd2};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 2'd1, 16'd3};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 2'd1, 16'd4};

    // Preloaded burst, ready high: first beat RDLAT+1 cycles after release, no gaps.
    for (int s = 0; s < 2; s++) begin
      set_sel(s);
      do_reset();
      chk("rst_valid", out_valid[sel], 1'b0);
      chk("rst_level", level[sel], 2'd0);
      chk("rst_data", out_data[sel], 16'd0);
      for (int k = 1; k <= 8; k++) load(W'(k));
      for (int c = 0; c < 12; c++) begin
        tick(1'b0, 1'b1);
        chk("burst_valid", o_valid, (c >= s + 2) && (c <= s + 9));
      end
      chk("burst_beats", nbeats, 8);
    end

    // RDLAT=1 with ready toggling 1010...: each word once, in order.
    set_sel(0);
    do_reset();
    for (int k = 0; k < 16; k++) load(W'($urandom));
    for (int c = 0; c < 40; c++) tick(1'b0, (c % 2) == 0);
    chk("toggle_beats", nbeats, 16);
    chk("toggle_left", exp_q.size(), 0);

    // Table-driven backpressure sequence on RDLAT=2.
    set_sel(1);
    do_reset();
    for (int k = 1; k <= 10; k++) load(W'(k));
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, tbl[i].rdy);
      chk("tbl_read", o_read, tbl[i].rd);
      chk("tbl_valid", o_valid, tbl[i].vld);
      chk("tbl_level", o_level, tbl[i].lvl);
      chk("tbl_data", o_data, tbl[i].dat);
    end
    chk("bp_reads", nreads, 3);
    chk("bp_fifo_used", fwr[1] - frd[1], 7);
    for (int i = 8; i < 12; i++) begin
      tick(1'b0, tbl[i].rdy);
      chk("tbl_read", o_read, tbl[i].rd);
      chk("tbl_valid", o_valid, tbl[i].vld);
      chk("tbl_level", o_level, tbl[i].lvl);
      chk("tbl_data", o_data, tbl[i].dat);
    end

    // FIFO runs dry with two reads in flight.
    set_sel(1);
    do_reset();
    wa = W'($urandom);
    wb = W'($urandom);
    load(wa);
    load(wb);
    tick(1'b0, 1'b1); chk("dry_read0", o_read, 1'b1);
    tick(1'b0, 1'b1); chk("dry_read1", o_read, 1'b1);
    tick(1'b0, 1'b1); chk("dry_read2", o_read, 1'b0);
    tick(1'b0, 1'b1); chk("dry_v3", o_valid, 1'b1); chk("dry_d3", o_data, wa);
    tick(1'b0, 1'b1); chk("dry_v4", o_valid, 1'b1); chk("dry_d4", o_data, wb);
    tick(1'b0, 1'b1); chk("dry_v5", o_valid, 1'b0);
    tick(1'b0, 1'b1); chk("dry_v6", o_valid, 1'b0);

    // Reset with two reads in flight: nothing from before reset may surface.
    set_sel(1);
    do_reset();
    for (int k = 0; k < 4; k++) load(W'($urandom));
    tick(1'b0, 1'b1); chk("mr_read0", o_read, 1'b1);
    tick(1'b0, 1'b1); chk("mr_read1", o_read, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    chk("mr_valid", o_valid, 1'b0);
    chk("mr_level", o_level, 2'd0);
    for (int c = 0; c < 4; c++) begin
      tick(1'b0, 1'b1);
      chk("mr_quiet", o_valid, 1'b0);
    end

    // Randomized traffic on both latencies against the ordered scoreboard.
    for (int s = 0; s < 2; s++) begin
      set_sel(s);
      do_reset();
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 3) == 0 && (fwr[sel] - frd[sel]) < 12) begin
          for (int k = 0; k < int'($urandom_range(1, 3)); k++) load(W'($urandom));
        end
        tick(1'b0, $urandom_range(0, 99) < 60);
      end
      for (int c = 0; c < 40; c++) tick(1'b0, 1'b1);
      chk("rand_drained", exp_q.size(), 0);
      chk("rand_fifo_empty", fifo_empty[sel], 1'b1);
    end

`ifdef FIFO_RD_STREAM_STATS_EN
    // Starvation count, then saturation of the stall counter.
    set_sel(1);
    do_reset();
    for (int c = 0; c < 5; c++) tick(1'b0, 1'b1);
    chk("starve_4", starve_cnt[1], 16'd4);
    do_reset();
    for (int k = 0; k < 5; k++) load(W'($urandom));
    for (int c = 0; c < 70000; c++) tick(1'b0, 1'b0);
    chk("stall_sat", stall_cnt[1], 16'hFFFF);
    chk("starve_zero", starve_cnt[1], 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
